lookahead_mul_seq: RTL and testbench



---
 rtl/lookahead_mul_seq_if.sv | 29 ++
 rtl/lookahead_mul_seq.sv | 94 +++++++++
 tb/tb_lookahead_mul_seq.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/lookahead_mul_seq_if.sv
// Bundle for the sequential multiplier.
// It carries the requester handshake, the product return and the borrowed external 16-bit adder.
interface lookahead_mul_seq_if #(
    parameter int WIDTH = 16
);
    logic               start;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic               accept_rdy;
    logic               busy;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   add_x;
    logic [WIDTH-1:0]   add_y;
    logic               add_cin;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;

    // master: requester plus the external adder; slave: the multiplier controller
    modport master (
        output start, mcand, mplier, out_ready, add_sum, add_cout,
        input  accept_rdy, busy, out_valid, product, add_x, add_y, add_cin
    );
    modport slave (
        input  start, mcand, mplier, out_ready, add_sum, add_cout,
        output accept_rdy, busy, out_valid, product, add_x, add_y, add_cin
    );
endinterface

// File: rtl/lookahead_mul_seq.sv
// Sequential 16x16 unsigned shift-add multiplier.
// It time-shares one external carry-lookahead adder, using one add per cycle for 16 cycles.
module lookahead_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    lookahead_mul_seq_if.slave  bus,
    output logic [1:0]          dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST = 4'(WIDTH - 1);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   m_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   q_reg;
    logic [3:0]         cnt;
    logic [2*WIDTH-1:0] product_reg;
    logic               out_valid_reg;
    logic               accept;
    logic               take;
    logic               in_run;
    logic [2*WIDTH-1:0] shifted;

    // Handshakes: a start transfers when start & accept_rdy at a rising edge.
    // A product transfers when out_valid & out_ready; out_valid holds until then.
    assign in_run  = (state == RUN);
    assign accept  = (state == IDLE) | ((state == DONE) & bus.out_ready);
    assign take    = bus.start & accept;
    assign shifted = {bus.add_cout, bus.add_sum, q_reg[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.start) state_next = RUN;
            RUN:  if (cnt == LAST) state_next = DONE;
            DONE: if (bus.out_ready) state_next = bus.start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_reg         <= '0;
            a_reg         <= '0;
            q_reg         <= '0;
            cnt           <= '0;
            product_reg   <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            if ((state == DONE) && bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end
            if (take) begin
                m_reg <= bus.mcand;
                a_reg <= '0;
                q_reg <= bus.mplier;
                cnt   <= '0;
            end else if (in_run) begin
                // The 33-bit {cout, sum, Q} shifts right one place; Q[0] is retired.
                {a_reg, q_reg} <= shifted;
                cnt            <= cnt + 4'd1;
                if (cnt == LAST) begin
                    product_reg   <= shifted;
                    out_valid_reg <= 1'b1;
                end
            end
        end
    end

    assign bus.add_x      = in_run ? a_reg : '0;
    assign bus.add_y      = (in_run && q_reg[0]) ? m_reg : '0;
    assign bus.add_cin    = 1'b0;
    assign bus.accept_rdy = accept;
    assign bus.busy       = in_run;
    assign bus.out_valid  = out_valid_reg;
    assign bus.product    = product_reg;
    assign dbg_state      = state;
endmodule

// File: tb/tb_lookahead_mul_seq.sv
// Self-checking bench for lookahead_mul_seq with an ideal 16-bit adder model attached.
// Expected products come from plain 32-bit multiplication.
module tb_lookahead_mul_seq;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic        clk;
    logic        rst;
    logic [1:0]  dbg_state;
    logic [31:0] exp_q[$];
    int          n_cmp;
    int          n_err;

    lookahead_mul_seq_if bus ();

    lookahead_mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // external carry-lookahead adder, behaviourally
    assign {bus.add_cout, bus.add_sum} = 17'(bus.add_x) + 17'(bus.add_y) + 17'(bus.add_cin);

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] wa;
        logic [31:0] wb;
        wa = {16'd0, a};
        wb = {16'd0, b};
        return wa * wb;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // monitor / scoreboard: pops whenever a product is handed over
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_product", bus.product, 32'hxxxxxxxx);
            end else begin
                check("product", bus.product, exp_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic do_start(input logic [15:0] a, input logic [15:0] b);
        int w;
        w = 0;
        bus.start  = 1'b1;
        bus.mcand  = a;
        bus.mplier = b;
        @(negedge clk);
        while (!bus.accept_rdy && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("accept_timeout", 32'(w < 100), 32'd1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        exp_q.push_back(ref_mul(a, b));
        check("state_after_accept", 32'(dbg_state), 32'(S_RUN));
        check("valid_low_after_accept", 32'(bus.out_valid), 32'd0);
    endtask

    task automatic wait_valid(output int lat, output int busy_n, output bit saw_cout, output bit y_nz);
        lat      = 0;
        busy_n   = 0;
        saw_cout = 1'b0;
        y_nz     = 1'b0;
        while (!bus.out_valid && lat < 64) begin
            if (bus.busy) busy_n++;
            if (bus.busy && bus.add_cout) saw_cout = 1'b1;
            if (bus.add_y != 16'd0) y_nz = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_one(input string name, input logic [15:0] a, input logic [15:0] b,
                           output bit saw_cout, output bit y_nz);
        int lat;
        int busy_n;
        do_start(a, b);
        wait_valid(lat, busy_n, saw_cout, y_nz);
        check({name, "_latency"}, 32'(lat), 32'd16);
        check({name, "_busy_cycles"}, 32'(busy_n), 32'd16);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit saw_cout;
        bit y_nz;
        int lat;
        int busy_n;
        logic [31:0] hold_p;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.mcand = '0;
        bus.mplier = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_accept_rdy", 32'(bus.accept_rdy), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_product", bus.product, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));
        check("rst_add_xy", {bus.add_x, bus.add_y}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_one("mul3x5", 16'd3, 16'd5, saw_cout, y_nz);
        run_one("mulffff", 16'hFFFF, 16'hFFFF, saw_cout, y_nz);
        check("ffff_cout_seen", 32'(saw_cout), 32'd1);
        run_one("mplier0", 16'h1234, 16'h0000, saw_cout, y_nz);
        check("mplier0_add_y_zero", 32'(y_nz), 32'd0);
        run_one("mcand0", 16'h0000, 16'hABCD, saw_cout, y_nz);
        check("add_cin_idle", 32'(bus.add_cin), 32'd0);

        // start pulsed while busy is ignored; then backpressure holds the result
        bus.out_ready = 1'b0;
        do_start(16'h1111, 16'h2222);
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.mcand = 16'hDEAD;
        bus.mplier = 16'hBEEF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_valid(lat, busy_n, saw_cout, y_nz);
        check("ignored_start_latency", 32'(lat), 32'd12);
        hold_p = ref_mul(16'h1111, 16'h2222);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_product", bus.product, hold_p);
            check("hold_state", 32'(dbg_state), 32'(S_DONE));
        end
        @(posedge clk);
        #1;

        // DONE with out_ready=1 and start=1: handoff and accept on the same edge
        bus.out_ready = 1'b1;
        do_start(16'h00FF, 16'h0100);
        check("b2b_q_depth", 32'(exp_q.size()), 32'd1);
        wait_valid(lat, busy_n, saw_cout, y_nz);
        check("b2b_latency", 32'(lat), 32'd16);
        @(posedge clk);
        #1;

        // asynchronous reset mid-run at cnt=7
        do_start(16'h5555, 16'h3333);
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_state", 32'(dbg_state), 32'(S_IDLE));
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_product", bus.product, 32'd0);
        check("arst_accept_rdy", 32'(bus.accept_rdy), 32'd1);
        check("arst_busy", 32'(bus.busy), 32'd0);
        void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_one("mul7x9", 16'd7, 16'd9, saw_cout, y_nz);

        // random operands with random backpressure
        for (int k = 0; k < 12; k++) begin
            bus.out_ready = 1'b0;
            do_start(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
            wait_valid(lat, busy_n, saw_cout, y_nz);
            check("rand_latency", 32'(lat), 32'd16);
            repeat ($urandom_range(0, 4)) begin
                @(negedge clk);
                check("rand_hold_valid", 32'(bus.out_valid), 32'd1);
            end
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
        end

        begin
            int w;
            w = 0;
            while (exp_q.size() != 0 && w < 100) begin
                @(posedge clk);
                w++;
            end
            check("drain_empty", 32'(exp_q.size()), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
